multi_lane_fifo: RTL
====================

Name: multi_lane_fifo

Overview:
- Circular FIFO with variable-count parallel write and read.
- Each cycle the producer pushes 0..MAX_WRITE words and the consumer pops 0..MAX_READ words.
- Occupancy-based status replaces pointer-compare full/empty: exact count, free space, programmable almost-full/almost-empty, sticky overflow/underflow errors.
- Sits between GLB/NoC and PE scratchpads where ifmap/filter/psum streams arrive and depart in unequal bursts.

Parameters:
- DATA_WIDTH, 16, bits per word.
- MAX_WRITE, 4, max words pushed per cycle (≥1).
- MAX_READ, 4, max words popped per cycle (≥1).
- DEPTH, 16, storage in words; any integer ≥ max(MAX_WRITE, MAX_READ); need not be a power of 2.
- AF_THRESH, 12, almost_full asserted when count ≥ AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH.
- CW (derived), $clog2(DEPTH+1), count/space width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- clear  in  1  synchronous flush of pointers, count and error flags; lower priority than rstn.
- write_num  in  $clog2(MAX_WRITE+1)  words offered this cycle; 0 = no write.
- write_data  in  MAX_WRITE*DATA_WIDTH  lane i at bits [i*DW +: DW]; lane 0 written first.
- write_ready  out  1  combinational, equals (write_num ≤ space) and (write_num ≤ MAX_WRITE).
- read_num  in  $clog2(MAX_READ+1)  words requested this cycle; 0 = no read.
- read_ready  out  1  combinational, equals (read_num ≤ count) and (read_num ≤ MAX_READ).
- read_data  out  MAX_READ*DATA_WIDTH  show-ahead; lane i = mem[(rd_ptr+i) mod DEPTH].
- read_valid  out  MAX_READ  bit i high iff i < count.
- count  out  CW  words stored.
- space  out  CW  DEPTH − count.
- full / empty  out  1  count==DEPTH / count==0.
- almost_full / almost_empty  out  1  threshold compares on count.
- overflow / underflow  out  1  sticky error flags.

Behaviour:
- Reset (rstn=0 at edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
  - Outputs after reset: empty=1, full=0, space=DEPTH, read_valid=0, almost_empty=1, almost_full=(AF_THRESH==0).
  - Memory contents are not reset.
- clear=1: same effect as reset on pointers, count and flags; any write/read in that cycle is discarded.
- Write accept: w_acc = write_num when write_ready, else 0. No partial writes.
  - Accepted lanes 0..w_acc−1 go to mem[(wr_ptr+i) mod DEPTH].
  - wr_ptr advances by w_acc mod DEPTH.
- Read accept: r_acc = read_num when read_ready, else 0. No partial reads.
  - rd_ptr advances by r_acc mod DEPTH.
- Simultaneous read and write:
  - Both acceptances use pre-edge count/space. Space freed by a same-cycle read does not admit a write.
  - count_next = count + w_acc − r_acc.
  - Written data is not bypassed to read_data in the same cycle.
- Latency: a word written at edge N is visible on read_data/read_valid after edge N (earliest pop is the cycle after).
- Wrap-around:
  - All pointer sums use explicit modulo DEPTH (compare-and-subtract, not bit truncation), so non-power-of-2 depth works.
  - Multi-lane writes and reads may straddle the wrap point.
- Errors:
  - overflow set when write_num ≠ 0 and write_ready = 0.
  - underflow set when read_num ≠ 0 and read_ready = 0.
  - Both stay set until rstn or clear. A rejected request causes no state change other than the flag.
- Lanes i ≥ count on read_data carry stale memory; consumers must qualify with read_valid.
- No internal state machine beyond pointers/count. Status outputs are combinational from registered count only, never from current requests.

Test Plan:
- Reset → empty=1, count=0, space=16, read_valid=0000, overflow=0; then write_num=3 with lanes A,B,C → next cycle count=3, read_data lanes 0..2=A,B,C, read_valid=0111.
- Fill: four writes of 4 words (0..15) → full=1, almost_full=1 from count=12. Next write_num=1 → write_ready=0, overflow=1, count stays 16.
- Wrap with DEPTH=5, MAX_WRITE=MAX_READ=2 (all pointer sums including the write straddle modulo 5):
  - Push 0,1; push 2,3 (wr_ptr=4); pop 2 (rd_ptr=2); push 4,5 → 4 lands in slot 4, 5 wraps to slot 0.
  - Pop 2 (rd_ptr=4); read lane0=4, lane1=5 (pop straddles wrap); pop 2 → empty=1, rd_ptr=1.
- Simultaneous ops at count=15: write_num=2 with read_num=3 → write rejected (space 1, overflow=1), read accepted, count=12.
- Simultaneous ops at count=5: write_num=4 with read_num=4 → both accepted, count=5, data order preserved across 20 cycles of random legal traffic checked against a scoreboard.
- Read_num=2 at count=1 → read_ready=0, underflow=1, rd_ptr unchanged. Then clear=1 together with write_num=4 → count=0, underflow=0, no data written.
- Mid-burst rstn=0 at count=9 → next cycle count=0, empty=1, flags 0, and a subsequent single write/read returns the new word, not stale data.

Source files
------------

// File: rtl/multi_lane_fifo.sv
// Circular FIFO with variable-count multi-lane write and read per cycle.
// Status is derived from a registered occupancy count; errors are sticky.
module multi_lane_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WRITE  = 4,
  parameter int MAX_READ   = 4,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  localparam int CW  = $clog2(DEPTH + 1),
  localparam int WNW = $clog2(MAX_WRITE + 1),
  localparam int RNW = $clog2(MAX_READ + 1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clear,
  input  logic [WNW-1:0]                 write_num,
  input  logic [MAX_WRITE*DATA_WIDTH-1:0] write_data,
  output logic                           write_ready,
  input  logic [RNW-1:0]                 read_num,
  output logic                           read_ready,
  output logic [MAX_READ*DATA_WIDTH-1:0] read_data,
  output logic [MAX_READ-1:0]            read_valid,
  output logic [CW-1:0]                  count,
  output logic [CW-1:0]                  space,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;
  localparam int unsigned MW_U    = MAX_WRITE;
  localparam int unsigned MR_U    = MAX_READ;
  localparam int unsigned AF_U    = AF_THRESH;
  localparam int unsigned AE_U    = AE_THRESH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_idx [MAX_WRITE];
  logic [PW-1:0] rd_idx [MAX_READ];
  logic [31:0] wn_ext, rn_ext, count_ext, space_ext;
  logic [31:0] w_acc, r_acc;

  // Offsets never exceed DEPTH, so one compare-and-subtract is an exact modulo.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [31:0] off);
    logic [31:0] sum;
    sum = 32'(base) + off;
    if (sum >= DEPTH_U) sum = sum - DEPTH_U;
    return sum[PW-1:0];
  endfunction

  assign wn_ext    = 32'(write_num);
  assign rn_ext    = 32'(read_num);
  assign count_ext = 32'(count);
  assign space_ext = 32'(space);

  assign space        = CW'(DEPTH) - count;
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count_ext >= AF_U);
  assign almost_empty = (count_ext <= AE_U);

  assign write_ready = (wn_ext <= space_ext) && (wn_ext <= MW_U);
  assign read_ready  = (rn_ext <= count_ext) && (rn_ext <= MR_U);
  assign w_acc       = write_ready ? wn_ext : 32'd0;
  assign r_acc       = read_ready  ? rn_ext : 32'd0;

  always_comb begin
    for (int i = 0; i < MAX_WRITE; i++) wr_idx[i] = wrap_add(wr_ptr, 32'(i));
    for (int i = 0; i < MAX_READ; i++)  rd_idx[i] = wrap_add(rd_ptr, 32'(i));
  end

  // Show-ahead view; lanes beyond count hold stale words and rely on read_valid.
  always_comb begin
    read_data  = '0;
    read_valid = '0;
    for (int i = 0; i < MAX_READ; i++) begin
      read_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rd_idx[i]];
      read_valid[i] = (32'(i) < count_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !clear) begin
      for (int i = 0; i < MAX_WRITE; i++) begin
        if (32'(i) < w_acc) mem[wr_idx[i]] <= write_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wrap_add(wr_ptr, w_acc);
      rd_ptr <= wrap_add(rd_ptr, r_acc);
      count  <= CW'(count_ext + w_acc - r_acc);
      if (write_num != '0 && !write_ready) overflow  <= 1'b1;
      if (read_num != '0 && !read_ready)   underflow <= 1'b1;
    end
  end

endmodule
